// File: rtl/load_store_unit.sv
// load_store_unit: big-endian load/store bus initiator with read-modify-write for sub-word stores
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3;
  logic [1:0]  state, st_size;
  logic        st_store, st_uns, err, req_err;
  logic [31:0] st_addr, st_wdata, rdata, wword, ld_val, merged;
  logic [4:0]  sh;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  // lane 0 is the most significant byte, so the shift counts down from 24
  always_comb begin
    req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    sh = {~st_addr[1:0], 3'b000};
    rd_b = 8'(data_readdata >> sh);
    rd_h = st_addr[1] ? data_readdata[15:0] : data_readdata[31:16];
    ld_val = st_size == 2'b00 ? {{24{~st_uns & rd_b[7]}}, rd_b} : st_size == 2'b01 ? {{16{~st_uns & rd_h[15]}}, rd_h} : data_readdata;
    merged = st_size == 2'b00 ? (data_readdata & ~(32'hFF << sh)) | ({24'b0, st_wdata[7:0]} << sh) : st_addr[1] ? {data_readdata[31:16], st_wdata[15:0]} : {st_wdata[15:0], data_readdata[15:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      st_store <= 1'b0;
      st_size <= 2'b00;
      st_uns <= 1'b0;
      st_addr <= '0;
      st_wdata <= '0;
      rdata <= '0;
      wword <= '0;
      err <= 1'b0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        st_store <= req_store;
        st_size <= req_size;
        st_uns <= req_unsigned;
        st_addr <= req_addr;
        st_wdata <= req_wdata;
        wword <= req_wdata;
        rdata <= '0;
        err <= req_err;
        state <= req_err ? RESP : (!req_store || req_size != 2'b10) ? READ : WRITE;
      end
    end else if (state == READ) begin
      if (st_store) begin
        wword <= merged;
        state <= WRITE;
      end else begin
        rdata <= ld_val;
        state <= RESP;
      end
    end else begin
      state <= state == WRITE ? RESP : IDLE;
    end
  end
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_rdata = rdata;
  assign resp_error = err;
  assign data_read = state == READ;
  assign data_write = state == WRITE;
  assign data_address = (data_read || data_write) ? {st_addr[31:2], 2'b00} : '0;
  assign data_writedata = data_write ? wword : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a response scoreboard and a word memory model
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_error, data_read, data_write;
  logic [31:0] resp_rdata, data_address, data_writedata, data_readdata;
  logic [31:0] mem [0:63];
  logic        preload = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  int          cyc = 0, n_rd = 0, n_wr = 0, n_checks = 0, n_fail = 0;
  logic [31:0] last_raddr = '0, last_wdata = '0;
  typedef struct { logic [31:0] rdata; logic err; int at; } exp_t;
  exp_t q[$];

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error), .data_address(data_address),
    .data_read(data_read), .data_write(data_write), .data_writedata(data_writedata), .data_readdata(data_readdata)
  );

  always #5 clk = ~clk;
  assign data_readdata = mem[data_address[7:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (data_write) mem[data_address[7:2]] <= data_writedata;
    else if (preload) mem[pl_idx] <= pl_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (data_read) begin n_rd++; last_raddr = data_address; end
    if (data_write) begin n_wr++; last_wdata = data_writedata; end
    if (data_read && data_write) check("rd_wr_exclusive", 32'd1, 32'd0);
    if (resp_valid) begin
      if (q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", {31'b0, resp_error}, {31'b0, e.err});
        check("resp_cycle", cyc, e.at);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("resp_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int lat, input int rds, input int wrs);
    int r0, w0;
    exp_t e;
    r0 = n_rd; w0 = n_wr;
    check("ready_before", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    e.rdata = er; e.err = ee; e.at = cyc + lat - 1;
    q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    check("read_cycles", n_rd - r0, rds);
    check("write_cycles", n_wr - w0, wrs);
  endtask

  initial begin
    logic [9:0] acc;
    @(negedge clk);
    preload = 1'b1; pl_idx = 6'd4; pl_data = 32'h8899AABB;
    @(negedge clk);
    pl_idx = 6'd8; pl_data = 32'h11223344;
    @(negedge clk);
    preload = 1'b0; reset = 1'b0;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_error", {31'b0, resp_error}, 32'd0);
    check("rst_bus", {data_read, data_write, 30'b0}, 32'd0);
    check("rst_address", data_address, 32'd0);
    check("rst_writedata", data_writedata, 32'd0);
    issue(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 3, 1, 0);
    check("lw_address", last_raddr, 32'h10);
    issue(0, 2'b00, 0, 32'h11, 0, 32'hFFFFFF99, 0, 3, 1, 0);
    issue(0, 2'b00, 1, 32'h11, 0, 32'h00000099, 0, 3, 1, 0);
    issue(0, 2'b01, 0, 32'h12, 0, 32'hFFFFAABB, 0, 3, 1, 0);
    issue(0, 2'b01, 1, 32'h10, 0, 32'h00008899, 0, 3, 1, 0);
    issue(0, 2'b00, 0, 32'h13, 0, 32'hFFFFFFBB, 0, 3, 1, 0);
    issue(1, 2'b00, 0, 32'h13, 32'h12345677, 0, 0, 4, 1, 1);
    check("sb_writedata", last_wdata, 32'h8899AA77);
    check("sb_mem", mem[4], 32'h8899AA77);
    issue(1, 2'b01, 0, 32'h10, 32'h0000CAFE, 0, 0, 4, 1, 1);
    check("sh_mem", mem[4], 32'hCAFEAA77);
    issue(1, 2'b10, 0, 32'h14, 32'hDEADBEEF, 0, 0, 3, 0, 1);
    check("sw_mem", mem[5], 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h12, 0, 0, 1, 2, 0, 0);
    issue(1, 2'b01, 0, 32'h11, 32'hFFFF, 0, 1, 2, 0, 0);
    issue(0, 2'b11, 0, 32'h10, 0, 0, 1, 2, 0, 0);
    begin
      int w0;
      w0 = n_wr;
      req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55;
      @(negedge clk);
      req_valid = 1'b0;
      check("rmw_in_read", {31'b0, data_read}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      repeat (4) @(negedge clk);
      check("rst_mid_writes", n_wr - w0, 32'd0);
      check("rst_mid_mem", mem[8], 32'h11223344);
    end
    acc = '0;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      if (req_ready) begin
        exp_t e;
        acc[i] = 1'b1;
        e.rdata = 32'hCAFEAA77; e.err = 1'b0; e.at = cyc + 2;
        q.push_back(e);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    check("b2b_accepts", {22'b0, acc}, 32'b1001001001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
